one_to_two_st_demux: RTL and testbench

Pipelined 1:2 AXI4-Stream demultiplexer: routes one slave stream to master port A or B under control of `sel`, latched per packet at the first beat and held until `tlast`. Counterpart to the 2:1 streaming mux in Axis_Mux. Used to split a stream before parallel processing paths, or to fan packets out to two consumers. Each output has one registered stage, so latency is 1 cycle at full throughput.

---
 rtl/axis_mux_pkg.sv | 13 +
 rtl/axis_out_reg.sv | 35 +++
 rtl/one_to_two_st_demux.sv | 123 ++++++++++++
 tb/tb_one_to_two_st_demux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mux_pkg.sv
// Shared types and constants for the AXI4-Stream mux/demux blocks.
// Holds the packet FSM state type and the port select encodings.
package axis_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI4-Stream pipeline register.
// Ports: clk, reset, load/in_data/in_last, tready -> valid, data, last, free.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  tready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  free
);

  // Can take a new beat if empty or draining this cycle.
  assign free = !valid || tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      last  <= in_last;
    end else if (tready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/one_to_two_st_demux.sv
// Pipelined 1:2 AXI4-Stream demux; destination latched per packet from sel.
// Ports: s_axis_* in, m_axis_*_A/B out; pkt_cnt_A/B with DEMUX_PKT_CNT_EN.
module one_to_two_st_demux
  import axis_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_A,
  output logic                  m_axis_tvalid_A,
  input  logic                  m_axis_tready_A,
  output logic                  m_axis_tlast_A,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_B,
  output logic                  m_axis_tvalid_B,
  input  logic                  m_axis_tready_B,
  output logic                  m_axis_tlast_B
`ifdef DEMUX_PKT_CNT_EN
  ,
  output logic [31:0]           pkt_cnt_A,
  output logic [31:0]           pkt_cnt_B
`endif
);

  state_t state_q;
  state_t state_d;
  logic   dest_q;
  logic   dest_d;
  logic   target;
  logic   accept;
  logic   load_a;
  logic   load_b;
  logic   free_a;
  logic   free_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dest_q  <= SEL_A;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    unique case (state_q)
      IDLE: begin
        // Single-beat packets never leave IDLE.
        if (accept && !s_axis_tlast) begin
          state_d = IN_PKT;
          dest_d  = sel;
        end
      end
      IN_PKT: begin
        if (accept && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target        = (state_q == IN_PKT) ? dest_q : sel;
    s_axis_tready = (target == SEL_B) ? free_b : free_a;
    accept        = s_axis_tvalid && s_axis_tready;
    load_a        = accept && (target == SEL_A);
    load_b        = accept && (target == SEL_B);
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reg_a (
    .clk     (clk),
    .reset   (reset),
    .load    (load_a),
    .in_data (s_axis_tdata),
    .in_last (s_axis_tlast),
    .tready  (m_axis_tready_A),
    .valid   (m_axis_tvalid_A),
    .data    (m_axis_tdata_A),
    .last    (m_axis_tlast_A),
    .free    (free_a)
  );

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reg_b (
    .clk     (clk),
    .reset   (reset),
    .load    (load_b),
    .in_data (s_axis_tdata),
    .in_last (s_axis_tlast),
    .tready  (m_axis_tready_B),
    .valid   (m_axis_tvalid_B),
    .data    (m_axis_tdata_B),
    .last    (m_axis_tlast_B),
    .free    (free_b)
  );

`ifdef DEMUX_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_A <= '0;
      pkt_cnt_B <= '0;
    end else begin
      if (m_axis_tvalid_A && m_axis_tready_A && m_axis_tlast_A)
        pkt_cnt_A <= pkt_cnt_A + 32'd1;
      if (m_axis_tvalid_B && m_axis_tready_B && m_axis_tlast_B)
        pkt_cnt_B <= pkt_cnt_B + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_one_to_two_st_demux.sv
// Self-checking bench for one_to_two_st_demux: vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_one_to_two_st_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata_a;
  logic        m_tvalid_a;
  logic        m_tready_a;
  logic        m_tlast_a;
  logic [31:0] m_tdata_b;
  logic        m_tvalid_b;
  logic        m_tready_b;
  logic        m_tlast_b;
`ifdef DEMUX_PKT_CNT_EN
  logic [31:0] pkt_cnt_a;
  logic [31:0] pkt_cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  one_to_two_st_demux #(
    .DATA_WIDTH(32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sel             (sel),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .m_axis_tdata_A  (m_tdata_a),
    .m_axis_tvalid_A (m_tvalid_a),
    .m_axis_tready_A (m_tready_a),
    .m_axis_tlast_A  (m_tlast_a),
    .m_axis_tdata_B  (m_tdata_b),
    .m_axis_tvalid_B (m_tvalid_b),
    .m_axis_tready_B (m_tready_b),
    .m_axis_tlast_B  (m_tlast_b)
`ifdef DEMUX_PKT_CNT_EN
    ,
    .pkt_cnt_A       (pkt_cnt_a),
    .pkt_cnt_B       (pkt_cnt_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic tv, input logic s,
                       input logic [31:0] d, input logic l,
                       input logic ra, input logic rb);
    reset      = r;
    s_tvalid   = tv;
    sel        = s;
    s_tdata    = d;
    s_tlast    = l;
    m_tready_a = ra;
    m_tready_b = rb;
  endtask

  typedef struct {
    logic        rst;
    logic        tv;
    logic        sel;
    logic [31:0] d;
    logic        l;
    logic        ra;
    logic        rb;
    logic        e_rdy;
    logic        e_va;
    logic [31:0] e_da;
    logic        e_la;
    logic        e_vb;
    logic [31:0] e_db;
    logic        e_lb;
  } vec_t;

  vec_t vt[16];

  // Reference model state.
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  bit          m_in_pkt;
  bit          m_dest;
  int          cnt_a_m;
  int          cnt_b_m;

  initial begin
    // rst tv sel data l ra rb | rdy vA dA lA vB dB lB
    vt[0]  = '{1,1,0,32'h99,0,1,1, 1,0,32'h00,0,0,32'h00,0};
    vt[1]  = '{0,1,0,32'hAA,1,1,1, 1,1,32'hAA,1,0,32'h00,0};
    vt[2]  = '{0,1,1,32'hBB,1,1,1, 1,0,32'hAA,1,1,32'hBB,1};
    vt[3]  = '{0,1,0,32'h10,0,1,1, 1,1,32'h10,0,0,32'hBB,1};
    vt[4]  = '{0,1,1,32'h11,0,1,1, 1,1,32'h11,0,0,32'hBB,1};
    vt[5]  = '{0,1,0,32'h12,0,1,1, 1,1,32'h12,0,0,32'hBB,1};
    vt[6]  = '{0,1,1,32'h13,1,1,1, 1,1,32'h13,1,0,32'hBB,1};
    vt[7]  = '{0,1,0,32'h20,0,0,1, 0,1,32'h13,1,0,32'hBB,1};
    vt[8]  = '{0,1,0,32'h20,0,1,1, 1,1,32'h20,0,0,32'hBB,1};
    vt[9]  = '{0,1,1,32'h21,1,0,1, 0,1,32'h20,0,0,32'hBB,1};
    vt[10] = '{0,1,1,32'h21,1,0,1, 0,1,32'h20,0,0,32'hBB,1};
    vt[11] = '{0,1,1,32'h21,1,1,1, 1,1,32'h21,1,0,32'hBB,1};
    vt[12] = '{0,1,0,32'h55,1,1,1, 1,1,32'h55,1,0,32'hBB,1};
    vt[13] = '{0,1,1,32'h66,1,0,1, 1,1,32'h55,1,1,32'h66,1};
    vt[14] = '{0,0,1,32'h00,0,0,1, 1,1,32'h55,1,0,32'h66,1};
    vt[15] = '{0,0,0,32'h00,0,1,1, 1,0,32'h55,1,0,32'h66,1};

    drive(1, 0, 0, 0, 0, 1, 1);
    step();
    step();

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].rst, vt[i].tv, vt[i].sel, vt[i].d, vt[i].l,
            vt[i].ra, vt[i].rb);
      #1;
      chk($sformatf("v%0d_sready", i), 32'(s_tready), 32'(vt[i].e_rdy));
      step();
      chk($sformatf("v%0d_vA", i), 32'(m_tvalid_a), 32'(vt[i].e_va));
      chk($sformatf("v%0d_dA", i), m_tdata_a, vt[i].e_da);
      chk($sformatf("v%0d_lA", i), 32'(m_tlast_a), 32'(vt[i].e_la));
      chk($sformatf("v%0d_vB", i), 32'(m_tvalid_b), 32'(vt[i].e_vb));
      chk($sformatf("v%0d_dB", i), m_tdata_b, vt[i].e_db);
      chk($sformatf("v%0d_lB", i), 32'(m_tlast_b), 32'(vt[i].e_lb));
    end

    // Reset in the middle of a packet headed to A.
    drive(0, 1, 0, 32'h30, 0, 1, 1);
    step();
    chk("mid_vA", 32'(m_tvalid_a), 32'd1);
    chk("mid_dA", m_tdata_a, 32'h30);
    drive(1, 1, 0, 32'h31, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_vA", 32'(m_tvalid_a), 32'd0);
      chk("rst_vB", 32'(m_tvalid_b), 32'd0);
      chk("rst_dA", m_tdata_a, 32'd0);
      chk("rst_dB", m_tdata_b, 32'd0);
      chk("rst_lA", 32'(m_tlast_a), 32'd0);
      chk("rst_lB", 32'(m_tlast_b), 32'd0);
    end
    drive(0, 1, 1, 32'h40, 0, 1, 1);
    #1;
    chk("post_rst_sready", 32'(s_tready), 32'd1);
    step();
    chk("post_rst_vB", 32'(m_tvalid_b), 32'd1);
    chk("post_rst_dB", m_tdata_b, 32'h40);
    chk("post_rst_vA", 32'(m_tvalid_a), 32'd0);
    drive(0, 1, 0, 32'h41, 1, 1, 1);
    step();
    chk("post_rst_dB2", m_tdata_b, 32'h41);
    chk("post_rst_lB2", 32'(m_tlast_b), 32'd1);
    chk("post_rst_vA2", 32'(m_tvalid_a), 32'd0);
    drive(0, 0, 0, 0, 0, 1, 1);
    step();

`ifdef DEMUX_PKT_CNT_EN
    drive(1, 0, 0, 0, 0, 1, 1);
    step();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, (k >= 3), 32'(k), 1, 1, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    step();
    chk("cnt_A", pkt_cnt_a, 32'd3);
    chk("cnt_B", pkt_cnt_b, 32'd5);
`endif

    // Randomized run against the queue model.
    drive(1, 0, 0, 0, 0, 1, 1);
    step();
    step();
    qa.delete();
    qb.delete();
    m_in_pkt = 0;
    m_dest   = 0;
    cnt_a_m  = 0;
    cnt_b_m  = 0;
    for (int c = 0; c < 3000; c++) begin
      bit tgt;
      bit exp_rdy;
      drive(0, ($urandom % 4) != 0, 1'($urandom % 2), $urandom,
            ($urandom % 4) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0);
      #1;
      tgt     = m_in_pkt ? m_dest : sel;
      exp_rdy = tgt ? (qb.size() == 0 || m_tready_b)
                    : (qa.size() == 0 || m_tready_a);
      chk("rnd_sready", 32'(s_tready), 32'(exp_rdy));
      chk("rnd_vA", 32'(m_tvalid_a), 32'(qa.size() != 0));
      chk("rnd_vB", 32'(m_tvalid_b), 32'(qb.size() != 0));
      if (qa.size() != 0)
        chk("rnd_beatA", {m_tlast_a, m_tdata_a[30:0]},
            {qa[0][32], qa[0][30:0]});
      if (qb.size() != 0)
        chk("rnd_beatB", {m_tlast_b, m_tdata_b[30:0]},
            {qb[0][32], qb[0][30:0]});
`ifdef DEMUX_PKT_CNT_EN
      chk("rnd_cntA", pkt_cnt_a, 32'(cnt_a_m));
      chk("rnd_cntB", pkt_cnt_b, 32'(cnt_b_m));
`endif
      if (qa.size() != 0 && m_tready_a) begin
        if (qa[0][32]) cnt_a_m++;
        void'(qa.pop_front());
      end
      if (qb.size() != 0 && m_tready_b) begin
        if (qb[0][32]) cnt_b_m++;
        void'(qb.pop_front());
      end
      if (s_tvalid && exp_rdy) begin
        if (tgt) qb.push_back({s_tlast, s_tdata});
        else     qa.push_back({s_tlast, s_tdata});
        if (!m_in_pkt && !s_tlast) begin
          m_in_pkt = 1;
          m_dest   = sel;
        end else if (m_in_pkt && s_tlast) begin
          m_in_pkt = 0;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
